// File: rtl/cla_mp_add_sched_pkg.sv
// Shared types and constants for the multi-precision add scheduler.
package cla_sched_pkg;

    localparam int WORD_W    = 64;
    localparam int MAX_WORDS = 8;
    localparam int CNT_W     = $clog2(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/cla_mp_add_sched_if.sv
// Request/result bus of the scheduler.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1; the initiator holds valid and its payload stable until that edge,
// and ready may depend combinationally on valid.
interface cla_mp_add_sched_if #(
    parameter int WORDS = 2
);
    import cla_sched_pkg::*;

    localparam int W = WORD_W * WORDS;

    logic          req0_valid;
    logic          req0_ready;
    logic [W-1:0]  req0_a;
    logic [W-1:0]  req0_b;
    logic          req0_sub;

    logic          req1_valid;
    logic          req1_ready;
    logic [W-1:0]  req1_a;
    logic [W-1:0]  req1_b;
    logic          req1_sub;

    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_sum;
    logic          res_cout;
    req_id_t       res_id;

    // Requester/consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id
    );

endinterface

// File: rtl/cla_64bit.sv
// 64-bit carry-lookahead adder built from 4-bit lookahead groups.
module cla_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c_in,
    output logic [63:0] sum,
    output logic        c_out
);

    logic [63:0] g;
    logic [63:0] p;
    logic [64:0] c;

    // Carries inside each group are fully expanded; groups chain by group G/P.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c_in;
        for (int grp = 0; grp < 16; grp++) begin
            c[grp*4+1] = g[grp*4] | (p[grp*4] & c[grp*4]);
            c[grp*4+2] = g[grp*4+1] | (p[grp*4+1] & g[grp*4])
                       | (p[grp*4+1] & p[grp*4] & c[grp*4]);
            c[grp*4+3] = g[grp*4+2] | (p[grp*4+2] & g[grp*4+1])
                       | (p[grp*4+2] & p[grp*4+1] & g[grp*4])
                       | (p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
            c[grp*4+4] = g[grp*4+3] | (p[grp*4+3] & g[grp*4+2])
                       | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
                       | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4])
                       | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
        end
    end

    assign sum   = p ^ c[63:0];
    assign c_out = c[64];

endmodule

// File: rtl/cla_mp_add_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2
    import cla_sched_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output logic [1:0] grant
);

    // One-hot (or zero) grant from the request vector and the previous winner.
    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!valid[1] || last_grant == 1'b1)) begin
            grant[0] = 1'b1;
        end else if (valid[1]) begin
            grant[1] = 1'b1;
        end
    end

endmodule

// File: rtl/cla_mp_add_sched.sv
// Shares one 64-bit CLA between two requesters, running a WORDS x 64-bit
// add/subtract one word per cycle with the carry chained between words.
module cla_mp_add_sched
    import cla_sched_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_mp_add_sched_if.slave     bus,
    output state_t                dbg_state
);

    localparam int W = WORD_W * WORDS;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    req_id_t            last_grant;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry;
    logic               res_valid_q;
    logic [W-1:0]       res_sum_q;
    logic               res_cout_q;
    req_id_t            res_id_q;

    logic [1:0]         grant;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;
    logic               sel_sub;
    logic [WORD_W-1:0]  a_word;
    logic [WORD_W-1:0]  b_word;
    logic [WORD_W-1:0]  sum_word;
    logic               c_out;

    rr_arb2 u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Operands of whichever requester currently holds the grant.
    always_comb begin
        sel_a   = bus.req0_a;
        sel_b   = bus.req0_b;
        sel_sub = bus.req0_sub;
        if (grant[1]) begin
            sel_a   = bus.req1_a;
            sel_b   = bus.req1_b;
            sel_sub = bus.req1_sub;
        end
    end

    assign bus.req0_ready = (state == IDLE) && grant[0] && !rst;
    assign bus.req1_ready = (state == IDLE) && grant[1] && !rst;

    assign a_word = a_q[cnt*WORD_W +: WORD_W];
    assign b_word = b_q[cnt*WORD_W +: WORD_W];

    cla_64bit u_cla (
        .a     (a_word),
        .b     (b_word),
        .c_in  (carry),
        .sum   (sum_word),
        .c_out (c_out)
    );

    // Control FSM plus operand/result registers; subtract stores ~B with carry-in 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            carry       <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        a_q        <= sel_a;
                        b_q        <= sel_sub ? ~sel_b : sel_b;
                        carry      <= sel_sub;
                        res_id_q   <= grant[1];
                        last_grant <= grant[1];
                        cnt        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    res_sum_q[cnt*WORD_W +: WORD_W] <= sum_word;
                    carry <= c_out;
                    if (cnt == CNT_W'(WORDS - 1)) begin
                        res_cout_q  <= c_out;
                        res_valid_q <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_id    = res_id_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_cla_mp_add_sched.sv
// Directed bench for cla_mp_add_sched with WORDS=2.
module tb_cla_mp_add_sched;
    import cla_sched_pkg::*;

    localparam int WORDS = 2;
    localparam int W     = WORD_W * WORDS;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     checks;
    int     failures;

    cla_mp_add_sched_if #(.WORDS(WORDS)) bus ();

    cla_mp_add_sched #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_sub   = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_sub   = 1'b0;
        bus.res_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Driver: present one request and hold it until accepted (bounded).
    // Returns at accept edge + 2 time units with valid already dropped.
    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output bit ok);
        ok = 1'b0;
        if (id == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) ok = 1'b1;
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.res_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic take_res();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b%b exp=00", bus.req1_ready, bus.req0_ready);
        end
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_sum !== '0 || bus.res_cout !== 1'b0 ||
            bus.res_id !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_values valid=%b sum=%h cout=%b id=%b state=%0d",
                     bus.res_valid, bus.res_sum, bus.res_cout, bus.res_id, dbg_state);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_tie got=%b%b exp=01", bus.req1_ready, bus.req0_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        bit ok;
        logic [W-1:0] a;
        logic [W-1:0] exp_sum;
        a       = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
        exp_sum = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
        send(0, a, 128'd1, 1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL lat_accept got=%b exp=1", ok);
        end
        checks++;
        if (bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_edge0 got=%b exp=0", bus.res_valid);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_edge1 got=%b exp=0", bus.res_valid);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL lat_edge2 got=%b exp=1", bus.res_valid);
        end
        checks++;
        if (bus.res_sum !== exp_sum || bus.res_cout !== 1'b0 || bus.res_id !== 1'b0) begin
            failures++;
            $display("FAIL lat_result sum=%h cout=%b id=%b exp sum=%h cout=0 id=0",
                     bus.res_sum, bus.res_cout, bus.res_id, exp_sum);
        end
        take_res();
        checks++;
        if (dbg_state !== IDLE || bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_release state=%0d valid=%b exp state=0 valid=0",
                     dbg_state, bus.res_valid);
        end
    endtask

    task automatic test_add_sub();
        int           t_id   [4];
        logic [W-1:0] t_a    [4];
        logic [W-1:0] t_b    [4];
        logic         t_sub  [4];
        logic [W-1:0] t_sum  [4];
        logic         t_cout [4];
        bit           ok;
        t_id[0] = 1; t_a[0] = {W{1'b1}};        t_b[0] = 128'd1;
        t_sub[0] = 1'b0; t_sum[0] = '0;         t_cout[0] = 1'b1;
        t_id[1] = 0; t_a[1] = 128'd5;           t_b[1] = 128'd3;
        t_sub[1] = 1'b1; t_sum[1] = 128'd2;     t_cout[1] = 1'b1;
        t_id[2] = 0; t_a[2] = 128'd0;           t_b[2] = 128'd1;
        t_sub[2] = 1'b1; t_sum[2] = {W{1'b1}};  t_cout[2] = 1'b0;
        t_id[3] = 1; t_a[3] = {1'b1, 127'd0};   t_b[3] = {1'b1, 127'd0};
        t_sub[3] = 1'b0; t_sum[3] = '0;         t_cout[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(t_id[i], t_a[i], t_b[i], t_sub[i], ok);
            if (ok) wait_res(ok);
            checks++;
            if (ok !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_timeout got=%b exp=1", i, ok);
            end
            checks++;
            if (bus.res_sum !== t_sum[i] || bus.res_cout !== t_cout[i] ||
                bus.res_id !== 1'(t_id[i])) begin
                failures++;
                $display("FAIL vec%0d sum=%h cout=%b id=%b exp sum=%h cout=%b id=%0d",
                         i, bus.res_sum, bus.res_cout, bus.res_id, t_sum[i], t_cout[i], t_id[i]);
            end
            take_res();
        end
    endtask

    task automatic test_back_to_back();
        logic [0:0]   grant_q[$];
        logic [0:0]   id_q[$];
        logic [W-1:0] sum_q[$];
        logic [0:0]   exp_q[$];
        logic [W-1:0] exp_sum_q[$];
        int           both_cnt;
        exp_q     = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_sum_q = '{128'd2, 128'd4, 128'd2, 128'd4};
        both_cnt  = 0;
        do_reset();
        bus.req0_a = 128'd1; bus.req0_b = 128'd1; bus.req0_sub = 1'b0;
        bus.req1_a = 128'd2; bus.req1_b = 128'd2; bus.req1_sub = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (bus.req0_ready && bus.req1_ready) both_cnt++;
            if (bus.req0_ready) grant_q.push_back(1'b0);
            if (bus.req1_ready) grant_q.push_back(1'b1);
            if (bus.res_valid) begin
                id_q.push_back(bus.res_id);
                sum_q.push_back(bus.res_sum);
            end
            tick();
            #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        bus.res_ready = 1'b0;
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL b2b_two_ready got=%0d cycles exp=0", both_cnt);
        end
        checks++;
        if (grant_q.size() < 4 || id_q.size() < 4) begin
            failures++;
            $display("FAIL b2b_count grants=%0d results=%0d exp>=4",
                     grant_q.size(), id_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_q[i] !== exp_q[i] || id_q[i] !== exp_q[i] ||
                    sum_q[i] !== exp_sum_q[i]) begin
                    failures++;
                    $display("FAIL b2b_op%0d grant=%b id=%b sum=%h exp grant/id=%b sum=%h",
                             i, grant_q[i], id_q[i], sum_q[i], exp_q[i], exp_sum_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        send(1, 128'd7, 128'd3, 1'b0, ok);
        if (ok) wait_res(ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL bp_timeout got=%b exp=1", ok);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_sum !== 128'd10 || bus.res_id !== 1'b1 ||
                bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d valid=%b sum=%h id=%b rdy=%b%b exp valid=1 sum=a id=1 rdy=00",
                         i, bus.res_valid, bus.res_sum, bus.res_id, bus.req1_ready, bus.req0_ready);
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        take_res();
        checks++;
        if (dbg_state !== IDLE || bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release state=%0d valid=%b exp state=0 valid=0",
                     dbg_state, bus.res_valid);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        send(1, 128'd9, 128'd4, 1'b0, ok);
        checks++;
        if (ok !== 1'b1 || dbg_state !== RUN) begin
            failures++;
            $display("FAIL mr_accept ok=%b state=%0d exp ok=1 state=1", ok, dbg_state);
        end
        rst = 1'b1;
        bus.req0_a = 128'd1; bus.req0_b = 128'd1; bus.req0_sub = 1'b0;
        bus.req1_a = 128'd2; bus.req1_b = 128'd2; bus.req1_sub = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL mr_ready_in_rst got=%b%b exp=00", bus.req1_ready, bus.req0_ready);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_sum !== '0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL mr_cleared valid=%b sum=%h state=%0d exp valid=0 sum=0 state=0",
                     bus.res_valid, bus.res_sum, dbg_state);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL mr_first_grant got=%b%b exp=01", bus.req1_ready, bus.req0_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_res(ok);
        checks++;
        if (ok !== 1'b1 || bus.res_sum !== 128'd2 || bus.res_id !== 1'b0) begin
            failures++;
            $display("FAIL mr_after ok=%b sum=%h id=%b exp ok=1 sum=2 id=0",
                     ok, bus.res_sum, bus.res_id);
        end
        take_res();
    endtask

    // Test sequence and final report
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_latency();
        test_add_sub();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
